// File: rtl/pe_ctrl_pkg.sv
// Package for the PE array controller.
// Holds the controller state encoding, the connection_state encodings, the
// default register-select width and a width helper shared by the controller files.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StFlush,
    StRound,
    StDrain,
    StDone
  } state_e;

  // connection_state encodings driven onto the array
  typedef enum logic [1:0] {
    ConnOff  = 2'd0,
    ConnRow  = 2'd1,
    ConnCol  = 2'd2,
    ConnSys  = 2'd3
  } conn_e;

  // Index width for n items, never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NREG_DEFAULT = 4;
  localparam int unsigned REG_SEL_W    = sel_width(NREG_DEFAULT);

endpackage

// File: rtl/pe_ctrl_lat_cnt.sv
// Reusable latency down-counter for the PE array controller.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_load       load i_load_val (has priority over i_tick)
//   i_load_val   value to load
//   i_tick       decrement by one; holds once at zero
//   o_zero       counter is zero
//   o_cnt        current count
module pe_ctrl_lat_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_zero,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for the PE array: accepts a tile command, clears the selected
// accumulator, streams K operand beats into the MACs, flushes the MAC pipeline,
// runs one rounder pass and drains one result column per beat.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_*                     tile command (valid/ready, k-1, acc/rnd select, conn)
//   op_valid / op_ready       operand beat handshake
//   pe_*                      shared array control lines
//   res_valid/res_ready/res_col  result column drain handshake
//   busy, done                status; done pulses one cycle after the last column
//   perf_stall                stall-cycle counter (only with PE_CTRL_PERF_EN)
// Build option: define PE_CTRL_PERF_EN to add the perf_stall counter output.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned COL     = 16,
  parameter int unsigned ROW     = 2,
  parameter int unsigned K_W     = 8,
  parameter int unsigned NREG    = NREG_DEFAULT,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned RND_LAT = 1,
  localparam int unsigned SEL_W  = (NREG == NREG_DEFAULT) ? REG_SEL_W : sel_width(NREG),
  localparam int unsigned COL_W  = sel_width(COL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [K_W-1:0]   cmd_k,
  input  logic [SEL_W-1:0] cmd_acc_sel,
  input  logic [SEL_W-1:0] cmd_rnd_sel,
  input  logic [1:0]       cmd_conn,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             pe_mac_en,
  output logic             pe_acc_clr,
  output logic [SEL_W-1:0] pe_add_number,
  output logic [SEL_W-1:0] pe_round_number,
  output logic             pe_rounder_en,
  output logic [1:0]       pe_conn_state,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [COL_W-1:0] res_col,
`ifdef PE_CTRL_PERF_EN
  output logic [15:0]      perf_stall,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned LAT_MAX = (MAC_LAT > RND_LAT) ? MAC_LAT : RND_LAT;
  localparam int unsigned CNT_W   = sel_width(LAT_MAX + 1);

  // ROW sizes nothing in the controller; reject a degenerate array at elaboration
  if (ROW == 0 || COL == 0) begin : g_param_chk
    $error("pe_array_ctrl: ROW and COL must be non-zero");
  end

  state_e             r_state, w_state_d;
  logic [K_W-1:0]     r_k;
  logic [SEL_W-1:0]   r_acc_sel, r_rnd_sel;
  conn_e              r_conn;
  logic [K_W-1:0]     r_beat, w_beat_d;
  logic [COL_W-1:0]   r_col, w_col_d;
  logic               w_accept;
  logic               w_lat_load, w_lat_tick, w_lat_zero;
  logic [CNT_W-1:0]   w_lat_load_val, w_lat_cnt;

  pe_ctrl_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lat_load),
    .i_load_val (w_lat_load_val),
    .i_tick     (w_lat_tick),
    .o_zero     (w_lat_zero),
    .o_cnt      (w_lat_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_k       <= '0;
      r_acc_sel <= '0;
      r_rnd_sel <= '0;
      r_conn    <= ConnOff;
      r_beat    <= '0;
      r_col     <= '0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_col   <= w_col_d;
      if (w_accept) begin
        r_k       <= cmd_k;
        r_acc_sel <= cmd_acc_sel;
        r_rnd_sel <= cmd_rnd_sel;
        r_conn    <= conn_e'(cmd_conn);
      end
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_beat_d        = r_beat;
    w_col_d         = r_col;
    w_accept        = 1'b0;
    w_lat_load      = 1'b0;
    w_lat_load_val  = '0;
    w_lat_tick      = 1'b0;
    cmd_ready       = 1'b0;
    op_ready        = 1'b0;
    pe_mac_en       = 1'b0;
    pe_acc_clr      = 1'b0;
    pe_add_number   = '0;
    pe_round_number = '0;
    pe_rounder_en   = 1'b0;
    res_valid       = 1'b0;
    res_col         = '0;
    done            = 1'b0;
    unique case (r_state)
      StIdle: begin
        // rst gating keeps every output low while reset is held
        cmd_ready = !rst;
        if (cmd_valid) begin
          w_accept  = 1'b1;
          w_state_d = StClear;
        end
      end
      StClear: begin
        pe_acc_clr    = 1'b1;
        pe_add_number = r_acc_sel;
        w_beat_d      = '0;
        w_state_d     = StMac;
      end
      StMac: begin
        op_ready      = 1'b1;
        pe_add_number = r_acc_sel;
        if (op_valid) begin
          pe_mac_en = 1'b1;
          w_beat_d  = r_beat + 1'b1;
          // compare before increment so k = 2^K_W-1 still runs 2^K_W beats
          if (r_beat == r_k) begin
            w_lat_load = 1'b1;
            if (MAC_LAT == 0) begin
              w_lat_load_val = CNT_W'(RND_LAT);
              w_state_d      = StRound;
            end else begin
              w_lat_load_val = CNT_W'(MAC_LAT - 1);
              w_state_d      = StFlush;
            end
          end
        end
      end
      StFlush: begin
        if (w_lat_zero) begin
          w_lat_load     = 1'b1;
          w_lat_load_val = CNT_W'(RND_LAT);
          w_state_d      = StRound;
        end else begin
          w_lat_tick = 1'b1;
        end
      end
      StRound: begin
        // counter still holds its load value only in the first ROUND cycle
        if (w_lat_cnt == CNT_W'(RND_LAT)) begin
          pe_rounder_en   = 1'b1;
          pe_round_number = r_rnd_sel;
        end
        if (w_lat_zero) begin
          w_col_d   = '0;
          w_state_d = StDrain;
        end else begin
          w_lat_tick = 1'b1;
        end
      end
      StDrain: begin
        res_valid = 1'b1;
        res_col   = r_col;
        if (res_ready) begin
          if (r_col == COL_W'(COL - 1)) begin
            w_col_d   = '0;
            w_state_d = StDone;
          end else begin
            w_col_d = r_col + 1'b1;
          end
        end
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign busy          = (r_state != StIdle);
  assign pe_conn_state = (r_state != StIdle) ? r_conn : ConnOff;

`ifdef PE_CTRL_PERF_EN
  logic [15:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = ((r_state == StMac) && !op_valid) || ((r_state == StDrain) && !res_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
    end else if (w_accept) begin
      r_perf_stall <= '0;
    end else if (w_stall && (r_perf_stall != 16'hFFFF)) begin
      r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

  localparam int unsigned COL     = 16;
  localparam int unsigned ROW     = 2;
  localparam int unsigned K_W     = 8;
  localparam int unsigned NREG    = 4;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned RND_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_k;
  logic [1:0] cmd_acc_sel, cmd_rnd_sel, cmd_conn;
  logic       op_valid, op_ready;
  logic       pe_mac_en, pe_acc_clr, pe_rounder_en;
  logic [1:0] pe_add_number, pe_round_number, pe_conn_state;
  logic       res_valid, res_ready;
  logic [3:0] res_col;
  logic       busy, done;
`ifdef PE_CTRL_PERF_EN
  logic [15:0] perf_stall;
`endif

  always #5 clk = ~clk;

  pe_array_ctrl #(
    .COL     (COL),
    .ROW     (ROW),
    .K_W     (K_W),
    .NREG    (NREG),
    .MAC_LAT (MAC_LAT),
    .RND_LAT (RND_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_k           (cmd_k),
    .cmd_acc_sel     (cmd_acc_sel),
    .cmd_rnd_sel     (cmd_rnd_sel),
    .cmd_conn        (cmd_conn),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .pe_mac_en       (pe_mac_en),
    .pe_acc_clr      (pe_acc_clr),
    .pe_add_number   (pe_add_number),
    .pe_round_number (pe_round_number),
    .pe_rounder_en   (pe_rounder_en),
    .pe_conn_state   (pe_conn_state),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_col         (res_col),
`ifdef PE_CTRL_PERF_EN
    .perf_stall      (perf_stall),
`endif
    .busy            (busy),
    .done            (done)
  );

  typedef struct packed {
    logic       cmd_ready;
    logic       op_ready;
    logic       mac_en;
    logic       acc_clr;
    logic [1:0] add_num;
    logic [1:0] rnd_num;
    logic       rnd_en;
    logic [1:0] conn;
    logic       res_valid;
    logic [3:0] res_col;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    string      name;
    logic       cv;
    logic [7:0] k;
    logic [1:0] as, rs, cn;
    logic       ov, rr;
    out_t       exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  // Expected outputs per controller phase
  function automatic out_t e_idle();
    out_t o = '0;
    o.cmd_ready = 1'b1;
    return o;
  endfunction

  function automatic out_t e_clear(logic [1:0] as, logic [1:0] cn);
    out_t o = '0;
    o.acc_clr = 1'b1; o.add_num = as; o.conn = cn; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_mac(logic [1:0] as, logic [1:0] cn, logic en);
    out_t o = '0;
    o.op_ready = 1'b1; o.mac_en = en; o.add_num = as; o.conn = cn; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_flush(logic [1:0] cn);
    out_t o = '0;
    o.conn = cn; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_round(logic [1:0] rs, logic [1:0] cn, logic en);
    out_t o = '0;
    o.rnd_en = en; o.rnd_num = en ? rs : 2'd0; o.conn = cn; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_drain(logic [1:0] cn, int col);
    out_t o = '0;
    o.res_valid = 1'b1; o.res_col = 4'(col); o.conn = cn; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_done(logic [1:0] cn);
    out_t o = '0;
    o.done = 1'b1; o.conn = cn; o.busy = 1'b1;
    return o;
  endfunction

  function automatic vec_t mkv(string name, logic cv, int k, logic [1:0] as, logic [1:0] rs,
                               logic [1:0] cn, logic ov, logic rr, out_t exp);
    vec_t v;
    v.name = name; v.cv = cv; v.k = 8'(k); v.as = as; v.rs = rs; v.cn = cn;
    v.ov = ov; v.rr = rr; v.exp = exp;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.cmd_ready = cmd_ready;     o.op_ready = op_ready;   o.mac_en = pe_mac_en;
    o.acc_clr   = pe_acc_clr;    o.add_num  = pe_add_number;
    o.rnd_num   = pe_round_number; o.rnd_en = pe_rounder_en;
    o.conn      = pe_conn_state; o.res_valid = res_valid; o.res_col = res_col;
    o.busy      = busy;          o.done     = done;
    return o;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h (cmd_rdy,op_rdy,mac,clr,add,rnd,rnd_en,conn,rv,col,busy,done)",
               name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check just after
  task automatic apply(input vec_t v);
    @(negedge clk);
    cmd_valid = v.cv; cmd_k = v.k; cmd_acc_sel = v.as; cmd_rnd_sel = v.rs;
    cmd_conn = v.cn; op_valid = v.ov; res_ready = v.rr;
    #1;
    chk(v.name, v.exp);
  endtask

  // Full tile with op_valid steady; hold keeps cmd_valid high through the run,
  // stall_col (if >= 0) holds res_ready low for 3 cycles at that column
  task automatic run_tile(input int k, input logic [1:0] as, input logic [1:0] rs,
                          input logic [1:0] cn, input logic hold, input int stall_col);
    apply(mkv("t_accept", 1'b1, k, as, rs, cn, 1'b1, 1'b0, e_idle()));
    apply(mkv("t_clear", hold, k, as, rs, cn, 1'b1, 1'b0, e_clear(as, cn)));
    for (int i = 0; i <= k; i++)
      apply(mkv("t_mac", hold, k, as, rs, cn, 1'b1, 1'b0, e_mac(as, cn, 1'b1)));
    for (int i = 0; i < int'(MAC_LAT); i++)
      apply(mkv("t_flush", hold, k, as, rs, cn, 1'b1, 1'b0, e_flush(cn)));
    apply(mkv("t_round_en", hold, k, as, rs, cn, 1'b1, 1'b0, e_round(rs, cn, 1'b1)));
    for (int i = 0; i < int'(RND_LAT); i++)
      apply(mkv("t_round_wait", hold, k, as, rs, cn, 1'b1, 1'b0, e_round(rs, cn, 1'b0)));
    for (int c = 0; c < int'(COL); c++) begin
      if (c == stall_col)
        for (int s = 0; s < 3; s++)
          apply(mkv("t_drain_stall", hold, k, as, rs, cn, 1'b0, 1'b0, e_drain(cn, c)));
      apply(mkv("t_drain", hold, k, as, rs, cn, 1'b0, 1'b1, e_drain(cn, c)));
    end
    apply(mkv("t_done", hold, k, as, rs, cn, 1'b0, 1'b0, e_done(cn)));
  endtask

  initial begin
    // Tile A: k=3, acc_sel=1, rnd_sel=1, conn=2, op_valid steady
    tbl.push_back(mkv("a_accept", 1, 3, 1, 1, 2, 0, 0, e_idle()));
    tbl.push_back(mkv("a_clear", 0, 3, 1, 1, 2, 1, 0, e_clear(1, 2)));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv("a_mac", 0, 3, 1, 1, 2, 1, 0, e_mac(1, 2, 1)));
    for (int i = 0; i < 2; i++) tbl.push_back(mkv("a_flush", 0, 3, 1, 1, 2, 1, 0, e_flush(2)));
    tbl.push_back(mkv("a_round_en", 0, 3, 1, 1, 2, 1, 0, e_round(1, 2, 1)));
    tbl.push_back(mkv("a_round_wait", 0, 3, 1, 1, 2, 1, 0, e_round(1, 2, 0)));
    for (int c = 0; c < 16; c++) tbl.push_back(mkv("a_drain", 0, 3, 1, 1, 2, 0, 1, e_drain(2, c)));
    tbl.push_back(mkv("a_done", 0, 3, 1, 1, 2, 0, 1, e_done(2)));
    tbl.push_back(mkv("a_idle", 0, 3, 1, 1, 2, 0, 1, e_idle()));
    // Tile B: k=4, acc_sel=2, rnd_sel=3, conn=1, op_valid 1-0-1-0..., 5 beats over 9 cycles
    tbl.push_back(mkv("b_accept", 1, 4, 2, 3, 1, 0, 0, e_idle()));
    tbl.push_back(mkv("b_clear", 0, 4, 2, 3, 1, 0, 0, e_clear(2, 1)));
    for (int i = 0; i < 9; i++) begin
      logic ov;
      ov = (i % 2 == 0);
      tbl.push_back(mkv("b_mac", 0, 4, 2, 3, 1, ov, 0, e_mac(2, 1, ov)));
    end
    for (int i = 0; i < 2; i++) tbl.push_back(mkv("b_flush", 0, 4, 2, 3, 1, 1, 0, e_flush(1)));
    tbl.push_back(mkv("b_round_en", 0, 4, 2, 3, 1, 0, 0, e_round(3, 1, 1)));
    tbl.push_back(mkv("b_round_wait", 0, 4, 2, 3, 1, 0, 0, e_round(3, 1, 0)));
    for (int c = 0; c < 16; c++) tbl.push_back(mkv("b_drain", 0, 4, 2, 3, 1, 0, 1, e_drain(1, c)));
    tbl.push_back(mkv("b_done", 0, 4, 2, 3, 1, 0, 1, e_done(1)));
    tbl.push_back(mkv("b_idle", 0, 4, 2, 3, 1, 0, 0, e_idle()));

    rst = 1'b1; cmd_valid = 1'b0; cmd_k = '0; cmd_acc_sel = '0; cmd_rnd_sel = '0;
    cmd_conn = '0; op_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs", '0);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset_release_idle", e_idle());

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Output backpressure at column 7
    run_tile(5, 3, 0, 2, 1'b0, 7);
    apply(mkv("bp_idle", 0, 0, 0, 0, 0, 0, 0, e_idle()));

    // Reset in the middle of MAC, after two beats
    apply(mkv("rm_accept", 1, 6, 2, 1, 3, 1, 0, e_idle()));
    apply(mkv("rm_clear", 0, 6, 2, 1, 3, 1, 0, e_clear(2, 3)));
    apply(mkv("rm_mac", 0, 6, 2, 1, 3, 1, 0, e_mac(2, 3, 1)));
    apply(mkv("rm_mac", 0, 6, 2, 1, 3, 1, 0, e_mac(2, 3, 1)));
    @(negedge clk); rst = 1'b1; op_valid = 1'b1; #1;
    chk("rm_in_reset", '0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rm_after_reset", e_idle());
    run_tile(2, 1, 3, 1, 1'b0, -1);
    apply(mkv("rm_idle", 0, 0, 0, 0, 0, 0, 0, e_idle()));

    // Maximum length with cmd_valid held, then a back-to-back second command
    run_tile(255, 3, 2, 3, 1'b1, -1);
    run_tile(1, 0, 1, 1, 1'b0, -1);
    apply(mkv("b2b_idle", 0, 0, 0, 0, 0, 0, 0, e_idle()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
